// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with a sign-fix pass before writeback.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       mdOp_i,
  input  logic [WIDTH-1:0] opA_i,
  input  logic [WIDTH-1:0] opB_i,
  input  logic             cancel_i,
  input  logic             writeHi_i,
  input  logic             writeLo_i,
  input  logic [WIDTH-1:0] wrData_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divZero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opB_q;
  logic [WIDTH-1:0]     origA_q;
  logic                 isDiv_q;
  logic                 bZero_q;
  logic                 negQ_q;
  logic                 negR_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 divZero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 aNeg;
  logic                 bNeg;
  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       remShift;
  logic [WIDTH:0]       remDiff;
  logic [2*WIDTH-1:0]   mulStep_d;
  logic [2*WIDTH-1:0]   divStep_d;
  logic [2*WIDTH-1:0]   fixAcc_d;
  logic [WIDTH-1:0]     fixQ;
  logic [WIDTH-1:0]     fixR;

  // Divide keeps remainder in acc[2W-1:W] and shifts the dividend/quotient through acc[W-1:0].
  always_comb begin
    aNeg      = mdOp_i[0] & opA_i[WIDTH-1];
    bNeg      = mdOp_i[0] & opB_i[WIDTH-1];
    absA      = aNeg ? (~opA_i + WIDTH'(1)) : opA_i;
    absB      = bNeg ? (~opB_i + WIDTH'(1)) : opB_i;
    mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
    mulStep_d = {mulSum, acc_q[WIDTH-1:1]};
    remShift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    remDiff   = remShift - {1'b0, opB_q};
    divStep_d = remDiff[WIDTH] ? {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {remDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    fixQ      = negQ_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    fixR      = negR_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];
    if (isDiv_q) fixAcc_d = {fixR, fixQ};
    else         fixAcc_d = negQ_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opB_q     <= '0;
      origA_q   <= '0;
      isDiv_q   <= 1'b0;
      bZero_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i && !cancel_i) begin
          state_q <= CALC;
          cnt_q   <= CNT_W'(WIDTH);
          acc_q   <= {{WIDTH{1'b0}}, absA};
          opB_q   <= absB;
          origA_q <= opA_i;
          isDiv_q <= mdOp_i[1];
          bZero_q <= (opB_i == '0);
          negQ_q  <= aNeg ^ bNeg;
          negR_q  <= aNeg;
          busy_q  <= 1'b1;
        end else if (!start_i) begin
          if (writeHi_i) hi_q <= wrData_i;
          if (writeLo_i) lo_q <= wrData_i;
        end
      end else if (cancel_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          CALC: begin
            acc_q <= isDiv_q ? divStep_d : mulStep_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= FIX;
          end
          FIX: begin
            acc_q   <= fixAcc_d;
            state_q <= DONE;
          end
          default: begin
            // A zero divisor bypasses the datapath result and returns the untouched dividend.
            if (isDiv_q && bZero_q) begin
              hi_q <= origA_q;
              lo_q <= '1;
            end else begin
              hi_q <= acc_q[2*WIDTH-1:WIDTH];
              lo_q <= acc_q[WIDTH-1:0];
            end
            divZero_q <= isDiv_q & bZero_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign divZero_o = divZero_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit that extends the execute-stage ALU with MULT/MULTU/DIV/DIVU.
- Keeps the architectural HI/LO result registers, supports direct HI/LO writes (MTHI/MTLO), and reports busy/done so the pipeline can stall on HI/LO reads.
- Iterative radix-2 datapath: shift-add for multiply, restoring division for divide.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be >= 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  launch an operation; accepted only in IDLE
- mdOp  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- opA  input  WIDTH  multiplicand / dividend; sampled with start
- opB  input  WIDTH  multiplier / divisor; sampled with start
- cancel  input  1  abort the in-flight operation (pipeline flush)
- writeHi  input  1  load HI from wrData (MTHI)
- writeLo  input  1  load LO from wrData (MTLO)
- wrData  input  WIDTH  data for writeHi/writeLo
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse in the cycle HI/LO receive a new result
- divZero  output  1  sticky flag: last completed op was a divide by zero
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; hi, lo = 0; busy, done, divZero = 0; counter and working registers = 0. A reset mid-operation discards it without a done pulse.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start = 1: latch mdOp, and take abs(opA) and abs(opB) for signed ops (raw values for unsigned ops). Record result signs: quotient/product sign = signA ^ signB; remainder sign = signA. Go to CALC with counter = WIDTH. busy is high from the next cycle.
- CALC: one iteration per cycle for exactly WIDTH cycles, then FIX.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring; shift remainder and quotient left, subtract divisor, keep the result if non-negative.
- FIX: apply the sign correction with two's-complement negation.
  - Product: negated at 2*WIDTH bits.
  - Quotient and remainder: each negated at WIDTH bits.
- DONE: hi/lo are written, done = 1 for exactly this cycle, busy = 0 in this cycle.
  - Multiply: hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Divide: lo = quotient, hi = remainder.
  - divZero is set by a divide with opB == 0 and cleared by any other completed op.
- Latency: if start is sampled at edge N, done is high during the cycle after edge N+WIDTH+2, and hi/lo carry the new values in that same cycle.
- Divide by zero (signed or unsigned): no exception. Result is hi = opA (original, unmodified), lo = all ones, divZero = 1; the normal WIDTH+2 latency is kept.
- Signed overflow, DIV of most-negative by -1: lo = most-negative, hi = 0. This falls out of the abs/negate datapath with no special case.
- start while busy: ignored, with no queuing.
- cancel: in any non-IDLE state, return to IDLE on the next edge. hi, lo and divZero are unchanged and there is no done pulse. If cancel and start are high together in IDLE, cancel wins and no operation starts.
- writeHi/writeLo:
  - Honoured only when busy = 0 and start = 0; ignored otherwise.
  - Take effect on the next edge.
  - Both may be asserted together.
  - They do not change divZero.
- hi/lo hold their value except on DONE, on an honoured write, or on reset.
- Widths: all arithmetic is modulo 2^WIDTH per result half. There are no X outputs for any input combination.

Test Plan (WIDTH=32):
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> done exactly 34 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for the intervening cycles.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, divZero=0.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, divZero=1. A subsequent DIVU 100 / 7 -> lo=14, hi=2, divZero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Preload with writeHi=1, writeLo=1, wrData=0x12345678. Start MULTU, pulse a second start at cycle 5 (ignored), then assert cancel at cycle 10. Expect busy low after the next edge, no done pulse, hi=lo=0x12345678. A writeLo issued while busy leaves lo unchanged.
- Deassert rst_n asynchronously at cycle 20 of a DIVU -> hi, lo, busy, done, divZero all 0 immediately. After release, a fresh MULTU 6 x 7 -> lo=42, hi=0.
